// File: rtl/sb_axi_pkg.sv
// Shared widths, packed-field offsets and status bit indices for the switchboard AXI master bridge.
package sb_axi_pkg;

    localparam int unsigned PROT_W   = 3;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned LOCK_W   = 1;
    localparam int unsigned CACHE_W  = 4;
    localparam int unsigned RESP_W   = 2;
    localparam int unsigned AX_FIXED_W = PROT_W + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W;

    localparam int unsigned PE_WLAST   = 0;
    localparam int unsigned PE_B_UNSOL = 1;
    localparam int unsigned PE_R_UNSOL = 2;
    localparam int unsigned PE_W       = 3;

    function automatic int unsigned ax_width(int unsigned aw, int unsigned iw);
        return aw + iw + AX_FIXED_W;
    endfunction

    function automatic int unsigned w_width(int unsigned dw, int unsigned sw);
        return dw + sw + 1;
    endfunction

    function automatic int unsigned b_width(int unsigned iw);
        return iw + RESP_W;
    endfunction

    function automatic int unsigned r_width(int unsigned dw, int unsigned iw);
        return dw + iw + RESP_W + 1;
    endfunction

    // AW/AR packing, LSB first: addr, prot, id, len, size, burst, lock, cache
    function automatic int unsigned ax_prot_lsb(int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned ax_id_lsb(int unsigned aw);
        return aw + PROT_W;
    endfunction

    function automatic int unsigned ax_len_lsb(int unsigned aw, int unsigned iw);
        return aw + PROT_W + iw;
    endfunction

    function automatic int unsigned ax_size_lsb(int unsigned aw, int unsigned iw);
        return ax_len_lsb(aw, iw) + LEN_W;
    endfunction

    function automatic int unsigned ax_burst_lsb(int unsigned aw, int unsigned iw);
        return ax_size_lsb(aw, iw) + SIZE_W;
    endfunction

    function automatic int unsigned ax_lock_lsb(int unsigned aw, int unsigned iw);
        return ax_burst_lsb(aw, iw) + BURST_W;
    endfunction

    function automatic int unsigned ax_cache_lsb(int unsigned aw, int unsigned iw);
        return ax_lock_lsb(aw, iw) + LOCK_W;
    endfunction

    // Smallest power of two >= n, never below 2 (FIFO depth requirement)
    function automatic int unsigned pow2_depth(int unsigned n);
        int unsigned d;
        d = 2;
        for (int i = 0; i < 8; i++) begin
            if (d < n) d = d * 2;
        end
        return d;
    endfunction

endpackage

// File: rtl/sb_axi_m_buf_if.sv
// AXI4 bus bundle between the buffered master bridge and an AXI slave.
interface sb_axi_m_buf_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [ID_WIDTH-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arready,
        input  rvalid, rdata, rid, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
        output arready,
        output rvalid, rdata, rid, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/sb_axi_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers; head entry is read straight from storage registers.
module sb_axi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign do_pop  = pop && !empty;
    // a pop frees the slot being written, so a full FIFO may push in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= din;
        end
    end
endmodule

// File: rtl/sb_axi_m_buf.sv
// Buffered AXI4 master bridge with outstanding-transaction throttling.
// Optional W/B/R protocol checker enabled by defining SB_AXI_M_BUF_CHECK_EN.
module sb_axi_m_buf
    import sb_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WR_OUT = 4,
    parameter int unsigned MAX_RD_OUT = 4
) (
    input  logic clk,
    input  logic nreset,

    input  logic [ax_width(ADDR_WIDTH, ID_WIDTH)-1:0]   aw_in_data,
    input  logic                                        aw_in_valid,
    output logic                                        aw_in_ready,
    input  logic [w_width(DATA_WIDTH, STRB_WIDTH)-1:0]  w_in_data,
    input  logic                                        w_in_valid,
    output logic                                        w_in_ready,
    input  logic [ax_width(ADDR_WIDTH, ID_WIDTH)-1:0]   ar_in_data,
    input  logic                                        ar_in_valid,
    output logic                                        ar_in_ready,

    output logic [b_width(ID_WIDTH)-1:0]                b_out_data,
    output logic                                        b_out_valid,
    input  logic                                        b_out_ready,
    output logic [r_width(DATA_WIDTH, ID_WIDTH)-1:0]    r_out_data,
    output logic                                        r_out_valid,
    input  logic                                        r_out_ready,

    sb_axi_m_buf_if.master                              m_axi,

    output logic [7:0]                                  wr_outstanding,
    output logic [7:0]                                  rd_outstanding,
    output logic                                        idle,
    output logic [PE_W-1:0]                             prot_err
);
    localparam int unsigned AXW = ax_width(ADDR_WIDTH, ID_WIDTH);
    localparam int unsigned WW  = w_width(DATA_WIDTH, STRB_WIDTH);
    localparam int unsigned BW  = b_width(ID_WIDTH);
    localparam int unsigned RW  = r_width(DATA_WIDTH, ID_WIDTH);

    localparam int unsigned PROT_LSB  = ax_prot_lsb(ADDR_WIDTH);
    localparam int unsigned ID_LSB    = ax_id_lsb(ADDR_WIDTH);
    localparam int unsigned LEN_LSB   = ax_len_lsb(ADDR_WIDTH, ID_WIDTH);
    localparam int unsigned SIZE_LSB  = ax_size_lsb(ADDR_WIDTH, ID_WIDTH);
    localparam int unsigned BURST_LSB = ax_burst_lsb(ADDR_WIDTH, ID_WIDTH);
    localparam int unsigned LOCK_LSB  = ax_lock_lsb(ADDR_WIDTH, ID_WIDTH);
    localparam int unsigned CACHE_LSB = ax_cache_lsb(ADDR_WIDTH, ID_WIDTH);

    logic           rst_done;
    logic [AXW-1:0] aw_q, ar_q;
    logic [WW-1:0]  w_q;
    logic           aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
    logic           b_full, b_empty, r_full, r_empty;
    logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
    logic [7:0]     wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d;
    logic           wr_dec, rd_dec;

    // Readys stay low until the first clock edge after reset release
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) rst_done <= 1'b0;
        else         rst_done <= 1'b1;
    end

    assign aw_in_ready = rst_done && !aw_full;
    assign w_in_ready  = rst_done && !w_full;
    assign ar_in_ready = rst_done && !ar_full;

    assign aw_hs     = m_axi.awvalid && m_axi.awready;
    assign w_hs      = m_axi.wvalid  && m_axi.wready;
    assign b_hs      = m_axi.bvalid  && m_axi.bready;
    assign ar_hs     = m_axi.arvalid && m_axi.arready;
    assign r_hs      = m_axi.rvalid  && m_axi.rready;
    assign r_last_hs = r_hs && m_axi.rlast;

    sb_axi_fifo #(.WIDTH(AXW), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk, .rst_n(nreset), .push(aw_in_valid && aw_in_ready), .din(aw_in_data),
        .pop(aw_hs), .dout(aw_q), .full(aw_full), .empty(aw_empty));

    sb_axi_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk, .rst_n(nreset), .push(w_in_valid && w_in_ready), .din(w_in_data),
        .pop(w_hs), .dout(w_q), .full(w_full), .empty(w_empty));

    sb_axi_fifo #(.WIDTH(AXW), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk, .rst_n(nreset), .push(ar_in_valid && ar_in_ready), .din(ar_in_data),
        .pop(ar_hs), .dout(ar_q), .full(ar_full), .empty(ar_empty));

    sb_axi_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk, .rst_n(nreset), .push(b_hs), .din({m_axi.bid, m_axi.bresp}),
        .pop(b_out_valid && b_out_ready), .dout(b_out_data), .full(b_full), .empty(b_empty));

    sb_axi_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_r_fifo (
        .clk, .rst_n(nreset), .push(r_hs),
        .din({m_axi.rlast, m_axi.rid, m_axi.rresp, m_axi.rdata}),
        .pop(r_out_valid && r_out_ready), .dout(r_out_data), .full(r_full), .empty(r_empty));

    // The gate only blocks new assertion: the count cannot rise while a request waits for ready
    assign m_axi.awvalid = !aw_empty && (wr_cnt < 8'(MAX_WR_OUT));
    assign m_axi.awaddr  = aw_q[ADDR_WIDTH-1:0];
    assign m_axi.awprot  = aw_q[PROT_LSB  +: PROT_W];
    assign m_axi.awid    = aw_q[ID_LSB    +: ID_WIDTH];
    assign m_axi.awlen   = aw_q[LEN_LSB   +: LEN_W];
    assign m_axi.awsize  = aw_q[SIZE_LSB  +: SIZE_W];
    assign m_axi.awburst = aw_q[BURST_LSB +: BURST_W];
    assign m_axi.awlock  = aw_q[LOCK_LSB];
    assign m_axi.awcache = aw_q[CACHE_LSB +: CACHE_W];

    assign m_axi.wvalid  = !w_empty;
    assign m_axi.wdata   = w_q[DATA_WIDTH-1:0];
    assign m_axi.wstrb   = w_q[DATA_WIDTH +: STRB_WIDTH];
    assign m_axi.wlast   = w_q[DATA_WIDTH + STRB_WIDTH];

    assign m_axi.arvalid = !ar_empty && (rd_cnt < 8'(MAX_RD_OUT));
    assign m_axi.araddr  = ar_q[ADDR_WIDTH-1:0];
    assign m_axi.arprot  = ar_q[PROT_LSB  +: PROT_W];
    assign m_axi.arid    = ar_q[ID_LSB    +: ID_WIDTH];
    assign m_axi.arlen   = ar_q[LEN_LSB   +: LEN_W];
    assign m_axi.arsize  = ar_q[SIZE_LSB  +: SIZE_W];
    assign m_axi.arburst = ar_q[BURST_LSB +: BURST_W];
    assign m_axi.arlock  = ar_q[LOCK_LSB];
    assign m_axi.arcache = ar_q[CACHE_LSB +: CACHE_W];

    assign m_axi.bready  = rst_done && !b_full;
    assign m_axi.rready  = rst_done && !r_full;
    assign b_out_valid   = !b_empty;
    assign r_out_valid   = !r_empty;

    // Outstanding counters; a response with nothing outstanding is ignored (saturate at 0)
    assign wr_dec = b_hs && (wr_cnt != 8'd0);
    assign rd_dec = r_last_hs && (rd_cnt != 8'd0);

    always_comb begin
        wr_cnt_d = wr_cnt;
        rd_cnt_d = rd_cnt;
        if (aw_hs && !wr_dec)      wr_cnt_d = wr_cnt + 8'd1;
        else if (!aw_hs && wr_dec) wr_cnt_d = wr_cnt - 8'd1;
        if (ar_hs && !rd_dec)      rd_cnt_d = rd_cnt + 8'd1;
        else if (!ar_hs && rd_dec) rd_cnt_d = rd_cnt - 8'd1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_cnt <= 8'd0;
            rd_cnt <= 8'd0;
        end else begin
            wr_cnt <= wr_cnt_d;
            rd_cnt <= rd_cnt_d;
        end
    end

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;
    assign idle = aw_empty && w_empty && ar_empty && b_empty && r_empty &&
                  (wr_cnt == 8'd0) && (rd_cnt == 8'd0);

`ifdef SB_AXI_M_BUF_CHECK_EN
    localparam int unsigned LEN_DEPTH = pow2_depth(MAX_WR_OUT);

    logic [LEN_W-1:0] len_q;
    logic             len_full, len_empty;
    logic [LEN_W-1:0] beat;
    logic [PE_W-1:0]  pe_q;

    sb_axi_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk, .rst_n(nreset), .push(aw_hs && !len_full), .din(m_axi.awlen),
        .pop(w_hs && m_axi.wlast), .dout(len_q), .full(len_full), .empty(len_empty));

    // Beat index within the current W burst
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                 beat <= '0;
        else if (w_hs && m_axi.wlast) beat <= '0;
        else if (w_hs)               beat <= beat + LEN_W'(1);
    end

    // Sticky protocol error flags
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pe_q <= '0;
        end else begin
            if (w_hs && !len_empty && (m_axi.wlast != (beat == len_q))) pe_q[PE_WLAST] <= 1'b1;
            if (b_hs && (wr_cnt == 8'd0)) pe_q[PE_B_UNSOL] <= 1'b1;
            if (r_hs && (rd_cnt == 8'd0)) pe_q[PE_R_UNSOL] <= 1'b1;
        end
    end

    assign prot_err = pe_q;
`else
    assign prot_err = '0;
`endif
endmodule

// File: tb/tb_sb_axi_m_buf.sv
// Directed self-checking bench for sb_axi_m_buf; the bench drives the AXI slave side by hand.
`timescale 1ns/1ps
module tb_sb_axi_m_buf;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned SW  = 4;
    localparam int unsigned IW  = 8;
    localparam int unsigned FD  = 4;
    localparam int unsigned MWO = 4;
    localparam int unsigned MRO = 2;
    localparam int unsigned AXW = AW + IW + 21;
    localparam int unsigned WW  = DW + SW + 1;
    localparam int unsigned BW  = IW + 2;
    localparam int unsigned RW  = DW + IW + 3;

`ifdef SB_AXI_M_BUF_CHECK_EN
    localparam logic [2:0] PE_AFTER_W = 3'b001;
    localparam logic [2:0] PE_AFTER_B = 3'b011;
`else
    localparam logic [2:0] PE_AFTER_W = 3'b000;
    localparam logic [2:0] PE_AFTER_B = 3'b000;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;

    logic [AXW-1:0] aw_in_data, ar_in_data;
    logic           aw_in_valid, ar_in_valid, w_in_valid;
    logic [WW-1:0]  w_in_data;
    logic           aw_in_ready, w_in_ready, ar_in_ready;
    logic [BW-1:0]  b_out_data;
    logic           b_out_valid, b_out_ready;
    logic [RW-1:0]  r_out_data;
    logic           r_out_valid, r_out_ready;
    logic [7:0]     wr_outstanding, rd_outstanding;
    logic           idle;
    logic [2:0]     prot_err;

    int total = 0;
    int bad   = 0;

    sb_axi_m_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) axi ();

    sb_axi_m_buf #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
        .FIFO_DEPTH(FD), .MAX_WR_OUT(MWO), .MAX_RD_OUT(MRO)
    ) dut (
        .clk(clk), .nreset(nreset),
        .aw_in_data(aw_in_data), .aw_in_valid(aw_in_valid), .aw_in_ready(aw_in_ready),
        .w_in_data(w_in_data), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .ar_in_data(ar_in_data), .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready),
        .b_out_data(b_out_data), .b_out_valid(b_out_valid), .b_out_ready(b_out_ready),
        .r_out_data(r_out_data), .r_out_valid(r_out_valid), .r_out_ready(r_out_ready),
        .m_axi(axi),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .idle(idle), .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [AXW-1:0] ax_pack(input logic [7:0] len, input logic [IW-1:0] id,
                                               input logic [AW-1:0] addr);
        return {4'b0011, 1'b0, 2'b01, 3'd2, len, id, 3'b000, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0;  axi.bid = '0;  axi.bresp = 2'b00;
        axi.rvalid = 1'b0;  axi.rid = '0;  axi.rresp = 2'b00;
        axi.rdata = '0;     axi.rlast = 1'b0;
    endtask

    task automatic test_reset();
        aw_in_valid = 1'b0; w_in_valid = 1'b0; ar_in_valid = 1'b0;
        aw_in_data = '0; w_in_data = '0; ar_in_data = '0;
        b_out_ready = 1'b0; r_out_ready = 1'b0;
        slave_idle();
        nreset = 1'b0;
        #12;
        total++;
        if ({aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready,
             axi.awvalid, axi.wvalid, axi.arvalid, b_out_valid, r_out_valid} !== 10'b0) begin
            bad++;
            $display("FAIL reset_vr: got %b exp 0", {aw_in_ready, w_in_ready, ar_in_ready,
                     axi.bready, axi.rready, axi.awvalid, axi.wvalid, axi.arvalid,
                     b_out_valid, r_out_valid});
        end
        total++;
        if ({wr_outstanding, rd_outstanding, idle, prot_err} !== {8'd0, 8'd0, 1'b1, 3'b000}) begin
            bad++;
            $display("FAIL reset_status: wr=%0d rd=%0d idle=%b pe=%b exp 0 0 1 000",
                     wr_outstanding, rd_outstanding, idle, prot_err);
        end
        nreset = 1'b1;
        #1;
        total++;
        if ({aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready} !== 5'b00000) begin
            bad++;
            $display("FAIL ready_before_edge: got %b exp 00000",
                     {aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready});
        end
        tick();
        total++;
        if ({aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready} !== 5'b11111) begin
            bad++;
            $display("FAIL ready_after_edge: got %b exp 11111",
                     {aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready});
        end
    endtask

    task automatic test_single_write();
        aw_in_data = ax_pack(8'd0, IW'(3), 16'h0010); aw_in_valid = 1'b1;
        w_in_data = {1'b1, 4'hF, 32'hDEADBEEF};       w_in_valid = 1'b1;
        tick();
        aw_in_valid = 1'b0; w_in_valid = 1'b0;
        total++;
        if ({axi.awvalid, axi.awaddr, axi.awid, axi.awlen} !== {1'b1, 16'h0010, 8'd3, 8'd0}) begin
            bad++;
            $display("FAIL wr_aw: v=%b addr=%h id=%0d len=%0d exp 1 0010 3 0",
                     axi.awvalid, axi.awaddr, axi.awid, axi.awlen);
        end
        total++;
        if ({axi.wvalid, axi.wdata, axi.wstrb, axi.wlast} !== {1'b1, 32'hDEADBEEF, 4'hF, 1'b1}) begin
            bad++;
            $display("FAIL wr_w: v=%b data=%h strb=%h last=%b exp 1 deadbeef f 1",
                     axi.wvalid, axi.wdata, axi.wstrb, axi.wlast);
        end
        axi.awready = 1'b1; axi.wready = 1'b1;
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0;
        total++;
        if ({wr_outstanding, axi.awvalid, axi.wvalid} !== {8'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL wr_issued: wr=%0d awv=%b wv=%b exp 1 0 0",
                     wr_outstanding, axi.awvalid, axi.wvalid);
        end
        axi.bvalid = 1'b1; axi.bid = IW'(3); axi.bresp = 2'b00;
        tick();
        axi.bvalid = 1'b0;
        total++;
        if ({b_out_valid, b_out_data, wr_outstanding} !== {1'b1, 8'd3, 2'b00, 8'd0}) begin
            bad++;
            $display("FAIL wr_b: v=%b data=%h wr=%0d exp 1 00c 0",
                     b_out_valid, b_out_data, wr_outstanding);
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        total++;
        if ({b_out_valid, idle} !== 2'b01) begin
            bad++;
            $display("FAIL wr_done: bv=%b idle=%b exp 0 1", b_out_valid, idle);
        end
    endtask

    task automatic test_read_burst();
        r_out_ready = 1'b1;
        ar_in_data = ax_pack(8'd3, IW'(5), 16'h0100); ar_in_valid = 1'b1;
        tick();
        ar_in_valid = 1'b0;
        total++;
        if ({axi.arvalid, axi.arlen, axi.arid, axi.araddr} !== {1'b1, 8'd3, 8'd5, 16'h0100}) begin
            bad++;
            $display("FAIL rd_ar: v=%b len=%0d id=%0d addr=%h exp 1 3 5 0100",
                     axi.arvalid, axi.arlen, axi.arid, axi.araddr);
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        total++;
        if ({rd_outstanding, axi.arvalid} !== {8'd1, 1'b0}) begin
            bad++;
            $display("FAIL rd_issued: rd=%0d arv=%b exp 1 0", rd_outstanding, axi.arvalid);
        end
        for (int i = 0; i < 4; i++) begin
            axi.rvalid = 1'b1; axi.rid = IW'(5); axi.rresp = 2'b00;
            axi.rdata = 32'hA000_0000 + DW'(i); axi.rlast = (i == 3);
            tick();
            total++;
            if ({r_out_valid, r_out_data, rd_outstanding} !==
                {1'b1, (i == 3), 8'd5, 2'b00, 32'hA000_0000 + DW'(i), (i == 3) ? 8'd0 : 8'd1}) begin
                bad++;
                $display("FAIL rd_beat%0d: v=%b data=%h rd=%0d", i, r_out_valid, r_out_data,
                         rd_outstanding);
            end
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        tick();
        total++;
        if ({r_out_valid, idle} !== 2'b01) begin
            bad++;
            $display("FAIL rd_done: rv=%b idle=%b exp 0 1", r_out_valid, idle);
        end
    endtask

    task automatic test_throttle();
        int hs;
        int guard;
        hs = 0;
        r_out_ready = 1'b1;
        axi.arready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            ar_in_valid = (c < 4);
            ar_in_data  = ax_pack(8'd0, IW'(c + 1), AW'(16'h0200 + c * 4));
            if (axi.arvalid && axi.arready) hs++;
            tick();
        end
        ar_in_valid = 1'b0;
        total++;
        if ({8'(hs), rd_outstanding, axi.arvalid} !== {8'd2, 8'd2, 1'b0}) begin
            bad++;
            $display("FAIL throttle_block: hs=%0d rd=%0d arv=%b exp 2 2 0", hs, rd_outstanding,
                     axi.arvalid);
        end
        axi.rvalid = 1'b1; axi.rid = IW'(1); axi.rlast = 1'b1; axi.rdata = '0;
        tick();
        axi.rvalid = 1'b0;
        total++;
        if ({rd_outstanding, axi.arvalid, axi.arid} !== {8'd1, 1'b1, 8'd3}) begin
            bad++;
            $display("FAIL throttle_release: rd=%0d arv=%b arid=%0d exp 1 1 3", rd_outstanding,
                     axi.arvalid, axi.arid);
        end
        tick();
        total++;
        if ({rd_outstanding, axi.arvalid} !== {8'd2, 1'b0}) begin
            bad++;
            $display("FAIL throttle_third: rd=%0d arv=%b exp 2 0", rd_outstanding, axi.arvalid);
        end
        guard = 0;
        while (!idle && guard < 40) begin
            axi.rvalid = (rd_outstanding != 8'd0); axi.rlast = 1'b1;
            tick();
            guard++;
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.arready = 1'b0;
        total++;
        if (idle !== 1'b1) begin
            bad++;
            $display("FAIL throttle_drain: idle=%b rd=%0d exp idle 1", idle, rd_outstanding);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        r_out_ready = 1'b0;
        ar_in_data = ax_pack(8'd7, IW'(6), 16'h0400); ar_in_valid = 1'b1;
        tick();
        ar_in_valid = 1'b0; axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            axi.rvalid = axi.rready && (sent < 8);
            axi.rdata = DW'(sent); axi.rid = IW'(6); axi.rresp = 2'b00; axi.rlast = (sent == 7);
            if (axi.rvalid) sent++;
            tick();
        end
        axi.rvalid = 1'b0;
        total++;
        if ({8'(sent), axi.rready, r_out_valid, r_out_data[DW-1:0]} !== {8'd4, 1'b0, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL bp_full: sent=%0d rready=%b rv=%b data=%h exp 4 0 1 0", sent,
                     axi.rready, r_out_valid, r_out_data[DW-1:0]);
        end
        r_out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (r_out_valid) begin
                total++;
                if (r_out_data !== {(got == 7), 8'd6, 2'b00, DW'(got)}) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got %h", got, r_out_data);
                end
                got++;
            end
            axi.rvalid = axi.rready && (sent < 8);
            axi.rdata = DW'(sent); axi.rlast = (sent == 7);
            if (axi.rvalid) sent++;
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        total++;
        if ({8'(got), 8'(sent), rd_outstanding, r_out_valid} !== {8'd8, 8'd8, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL bp_drain: got=%0d sent=%0d rd=%0d rv=%b exp 8 8 0 0", got, sent,
                     rd_outstanding, r_out_valid);
        end
    endtask

    task automatic test_check_and_saturate();
        b_out_ready = 1'b1;
        aw_in_data = ax_pack(8'd1, IW'(7), 16'h0300); aw_in_valid = 1'b1;
        tick();
        aw_in_valid = 1'b0; axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        w_in_data = {1'b1, 4'hF, 32'h1111_1111}; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0; axi.wready = 1'b1;
        tick();
        axi.wready = 1'b0;
        total++;
        if ({wr_outstanding, prot_err} !== {8'd1, PE_AFTER_W}) begin
            bad++;
            $display("FAIL chk_wlast: wr=%0d pe=%b exp 1 %b", wr_outstanding, prot_err, PE_AFTER_W);
        end
        axi.bvalid = 1'b1; axi.bid = IW'(7); axi.bresp = 2'b00;
        tick();
        total++;
        if ({wr_outstanding, prot_err} !== {8'd0, PE_AFTER_W}) begin
            bad++;
            $display("FAIL chk_sticky: wr=%0d pe=%b exp 0 %b", wr_outstanding, prot_err, PE_AFTER_W);
        end
        axi.bid = IW'(9);
        tick();
        axi.bvalid = 1'b0;
        total++;
        if ({wr_outstanding, prot_err, b_out_valid, b_out_data} !==
            {8'd0, PE_AFTER_B, 1'b1, 8'd9, 2'b00}) begin
            bad++;
            $display("FAIL chk_unsol_b: wr=%0d pe=%b bv=%b b=%h exp 0 %b 1 024", wr_outstanding,
                     prot_err, b_out_valid, b_out_data, PE_AFTER_B);
        end
        tick();
        tick();
        total++;
        if ({prot_err, b_out_valid, idle} !== {PE_AFTER_B, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL chk_hold: pe=%b bv=%b idle=%b exp %b 0 1", prot_err, b_out_valid,
                     idle, PE_AFTER_B);
        end
    endtask

    task automatic test_reset_mid();
        b_out_ready = 1'b0;
        aw_in_data = ax_pack(8'd7, IW'(2), 16'h0500); aw_in_valid = 1'b1;
        ar_in_data = ax_pack(8'd0, IW'(4), 16'h0600); ar_in_valid = 1'b1;
        w_in_data = {1'b0, 4'hF, 32'hB0B0_0000}; w_in_valid = 1'b1;
        tick();
        aw_in_valid = 1'b0; ar_in_valid = 1'b0;
        w_in_data = {1'b0, 4'hF, 32'hB0B0_0001}; axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        w_in_data = {1'b0, 4'hF, 32'hB0B0_0002};
        tick();
        w_in_valid = 1'b0;
        total++;
        if ({wr_outstanding, axi.wvalid, axi.arvalid, idle} !== {8'd1, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_pre: wr=%0d wv=%b arv=%b idle=%b exp 1 1 1 0", wr_outstanding,
                     axi.wvalid, axi.arvalid, idle);
        end
        #2;
        nreset = 1'b0;
        #1;
        total++;
        if ({aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready,
             axi.awvalid, axi.wvalid, axi.arvalid, b_out_valid, r_out_valid} !== 10'b0) begin
            bad++;
            $display("FAIL mid_vr: got %b exp 0", {aw_in_ready, w_in_ready, ar_in_ready,
                     axi.bready, axi.rready, axi.awvalid, axi.wvalid, axi.arvalid,
                     b_out_valid, r_out_valid});
        end
        total++;
        if ({wr_outstanding, rd_outstanding, idle, prot_err} !== {8'd0, 8'd0, 1'b1, 3'b000}) begin
            bad++;
            $display("FAIL mid_status: wr=%0d rd=%0d idle=%b pe=%b exp 0 0 1 000",
                     wr_outstanding, rd_outstanding, idle, prot_err);
        end
        slave_idle();
        tick();
        nreset = 1'b1;
        tick();
        total++;
        if ({aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready, idle} !== 6'b111111) begin
            bad++;
            $display("FAIL mid_recover: got %b exp 111111",
                     {aw_in_ready, w_in_ready, ar_in_ready, axi.bready, axi.rready, idle});
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_throttle();
        test_backpressure();
        test_check_and_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
